// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the requester ports and the round-robin arbiter.
// The master side drives requests and enable; the slave (arbiter) side returns the grant.
interface rr_arbiter_if #(
    parameter int N = 8
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic             enable;
    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;

    modport master (
        output enable,
        output req,
        input  grant,
        input  grant_idx,
        input  grant_valid
    );

    modport slave (
        input  enable,
        input  req,
        output grant,
        output grant_idx,
        output grant_valid
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with transaction hold, direct hand-off and MAX_HOLD pre-emption.
// All outputs are registered; grant follows the sampled req by one cycle.
module rr_arbiter #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arbiter_if.slave  bus
);
    localparam int          IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int          HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int unsigned NU     = N;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [N-1:0]      cand;
    logic              cand_any;
    logic [IDX_W-1:0]  pick_idx;
    logic              owner_req;
    logic              hold_max;

    // The owner is masked out of the candidates, so in BUSY cand_any means "someone else waits"
    always_comb begin
        cand      = (state_q == BUSY) ? (bus.req & ~grant_q) : bus.req;
        cand_any  = |cand;
        owner_req = |(bus.req & grant_q);
        hold_max  = (hold_q == HOLD_W'(MAX_HOLD - 1));
    end

    always_comb begin
        int unsigned j;
        logic        found;
        found    = 1'b0;
        pick_idx = '0;
        for (int unsigned k = 0; k < NU; k++) begin
            j = 32'(ptr_q) + k;
            if (j >= NU) j = j - NU;
            if (!found && cand[IDX_W'(j)]) begin
                found    = 1'b1;
                pick_idx = IDX_W'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;

        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                if (bus.enable && cand_any) begin
                    state_d = BUSY;
                    grant_d = '0;
                    grant_d[pick_idx] = 1'b1;
                    idx_d   = pick_idx;
                    ptr_d   = (pick_idx == IDX_W'(N - 1)) ? '0 : pick_idx + 1'b1;
                    hold_d  = '0;
                end
            end
            BUSY: begin
                if ((!owner_req || hold_max) && bus.enable && cand_any) begin
                    grant_d = '0;
                    grant_d[pick_idx] = 1'b1;
                    idx_d   = pick_idx;
                    ptr_d   = (pick_idx == IDX_W'(N - 1)) ? '0 : pick_idx + 1'b1;
                    hold_d  = '0;
                end else if (!owner_req) begin
                    state_d = IDLE;
                    grant_d = '0;
                    hold_d  = '0;
                end else if (!hold_max) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        valid_d = (state_d == BUSY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter (N=8, MAX_HOLD=4): vector table plus hand-written
// sequences for round-robin rotation and asynchronous reset mid-grant.
module tb_rr_arbiter;
    localparam int N  = 8;
    localparam int MH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_arbiter_if #(.N(N)) bus();

    rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] g;
        logic [2:0] idx;
        logic       v;
    } exp_t;

    typedef struct packed {
        logic       en;
        logic [7:0] req;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, queue the expectation, compare 1 ns after the next rising edge
    task automatic step(input string name, input logic en, input logic [7:0] r, input exp_t e);
        exp_t x;
        @(negedge clk);
        bus.enable = en;
        bus.req    = r;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            x = sb.pop_front();
            chk({name, " grant"}, 32'(bus.grant), 32'(x.g));
            chk({name, " valid"}, 32'(bus.grant_valid), 32'(x.v));
            if (x.v) chk({name, " idx"}, 32'(bus.grant_idx), 32'(x.idx));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.req    = '0;

        // en, req, expected grant, idx, valid after the next edge
        tbl.push_back('{1'b1, 8'h00, '{8'h00, 3'd0, 1'b0}});
        tbl.push_back('{1'b1, 8'h08, '{8'h08, 3'd3, 1'b1}});
        tbl.push_back('{1'b1, 8'h00, '{8'h00, 3'd0, 1'b0}});
        tbl.push_back('{1'b1, 8'h08, '{8'h08, 3'd3, 1'b1}});
        tbl.push_back('{1'b1, 8'h88, '{8'h08, 3'd3, 1'b1}});
        tbl.push_back('{1'b1, 8'h80, '{8'h80, 3'd7, 1'b1}});
        tbl.push_back('{1'b1, 8'h00, '{8'h00, 3'd0, 1'b0}});
        for (int i = 0; i < 10; i++)
            tbl.push_back('{1'b1, 8'h20, '{8'h20, 3'd5, 1'b1}});
        tbl.push_back('{1'b1, 8'h00, '{8'h00, 3'd0, 1'b0}});
        tbl.push_back('{1'b0, 8'h01, '{8'h00, 3'd0, 1'b0}});
        tbl.push_back('{1'b0, 8'h01, '{8'h00, 3'd0, 1'b0}});
        tbl.push_back('{1'b1, 8'h04, '{8'h04, 3'd2, 1'b1}});
        tbl.push_back('{1'b0, 8'h44, '{8'h04, 3'd2, 1'b1}});
        tbl.push_back('{1'b0, 8'h40, '{8'h00, 3'd0, 1'b0}});
        tbl.push_back('{1'b0, 8'h40, '{8'h00, 3'd0, 1'b0}});
        tbl.push_back('{1'b1, 8'h40, '{8'h40, 3'd6, 1'b1}});
        for (int i = 0; i < 4; i++)
            tbl.push_back('{1'b0, 8'h41, '{8'h40, 3'd6, 1'b1}});
        tbl.push_back('{1'b1, 8'h41, '{8'h01, 3'd0, 1'b1}});
        tbl.push_back('{1'b1, 8'h00, '{8'h00, 3'd0, 1'b0}});

        repeat (2) @(posedge clk);
        #1;
        chk("reset grant", 32'(bus.grant), 32'h0);
        chk("reset valid", 32'(bus.grant_valid), 32'h0);
        chk("reset idx",   32'(bus.grant_idx), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i].en, tbl[i].req, tbl[i].e);

        // Full rotation with every requester active: each owner holds exactly MAX_HOLD cycles
        do_reset();
        for (int o = 0; o < N; o++)
            for (int c = 0; c < MH; c++)
                step($sformatf("rr o%0d c%0d", o, c), 1'b1, 8'hFF,
                     '{8'(1 << o), 3'(o), 1'b1});
        step("rr wrap", 1'b1, 8'hFF, '{8'h01, 3'd0, 1'b1});
        step("rr wrap hold", 1'b1, 8'hFF, '{8'h01, 3'd0, 1'b1});

        // Asynchronous reset between edges, then restart from index 0
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst grant", 32'(bus.grant), 32'h0);
        chk("async rst valid", 32'(bus.grant_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post rst", 1'b1, 8'hFF, '{8'h01, 3'd0, 1'b1});
        step("post rst hold", 1'b1, 8'hFF, '{8'h01, 3'd0, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
